// File: rtl/adder_tree_sequencer.sv
// Sequences CHUNKS chunks of ELEMENTS 10-bit lanes into an external pipelined
// adder tree, accumulates the returning partial sums and presents the vector sum.
module adder_tree_sequencer #(
    parameter int unsigned ELEMENTS = 12,
    parameter int unsigned CHUNKS   = 4,
    parameter int unsigned TREE_LAT = 3
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ELEMENTS-1:0][9:0]   in_data,
    output logic [ELEMENTS-1:0][9:0]   tree_in,
    input  logic signed [9:0]          tree_out,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [9:0]          out_sum,
    output logic                       busy
);

    localparam int unsigned CntW    = $clog2(CHUNKS + 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(CHUNKS);

    typedef enum logic [1:0] {
        StIdle,
        StFeed,
        StDrain,
        StDone
    } state_e;

    state_e                   state_q, state_d;
    logic [CntW-1:0]          issue_cnt_q, issue_cnt_d;
    logic [CntW-1:0]          ret_cnt_q, ret_cnt_d;
    logic signed [9:0]        acc_q, acc_d;
    logic signed [9:0]        out_sum_q, out_sum_d;
    logic [TREE_LAT:0]        vld_q, vld_d;
    logic [ELEMENTS-1:0][9:0] tree_in_q, tree_in_d;
    logic                     accept;
    logic                     sample;

    // Handshake and status outputs decoded from the current state.
    always_comb begin
        // Held low during reset even though the state register already reads idle.
        in_ready  = rst_n_in && ((state_q == StIdle) || (state_q == StFeed));
        out_valid = (state_q == StDone);
        busy      = (state_q != StIdle);
        accept    = in_valid && in_ready;
        // Tail of the valid pipe marks the edge where tree_out belongs to an issued chunk.
        sample    = vld_q[TREE_LAT];
    end

    // Next-state, counters, accumulator and the chunk-in-flight tracker.
    always_comb begin
        state_d     = state_q;
        issue_cnt_d = issue_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        acc_d       = acc_q;
        out_sum_d   = out_sum_q;
        tree_in_d   = tree_in_q;

        vld_d    = vld_q << 1;
        vld_d[0] = accept;

        if (accept) begin
            tree_in_d   = in_data;
            issue_cnt_d = issue_cnt_q + CntW'(1);
        end

        if (sample) begin
            acc_d     = acc_q + tree_out;
            ret_cnt_d = ret_cnt_q + CntW'(1);
        end

        unique case (state_q)
            StIdle, StFeed: begin
                if (accept) begin
                    state_d = (issue_cnt_d == LastCnt) ? StDrain : StFeed;
                end
            end
            StDrain: begin
                if (sample && (ret_cnt_d == LastCnt)) begin
                    out_sum_d = acc_d;
                    state_d   = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d     = StIdle;
                    acc_d       = '0;
                    issue_cnt_d = '0;
                    ret_cnt_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= StIdle;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            acc_q       <= '0;
            out_sum_q   <= '0;
            vld_q       <= '0;
            tree_in_q   <= '0;
        end else begin
            state_q     <= state_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            acc_q       <= acc_d;
            out_sum_q   <= out_sum_d;
            vld_q       <= vld_d;
            tree_in_q   <= tree_in_d;
        end
    end

    assign tree_in = tree_in_q;
    assign out_sum = out_sum_q;

endmodule
